// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared FSM state type, default sizes and parity helper for data_mem_ctl
package data_mem_pkg;
    typedef enum logic {INIT, IDLE} mem_state_t;
    localparam int W_DEF = 8;
    localparam int AW_DEF = 8;
    localparam int PAR_MAX_W = 64;
    // Zero-extension leaves the XOR unchanged, so any W up to PAR_MAX_W fits.
    function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: bare storage array, one synchronous write port, combinational read, never reset
module mem_array #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] core [2**AW];
    always_ff @(posedge Clk) if (we) core[waddr] <= wdata;
    assign rdata = core[raddr];
endmodule

// File: rtl/data_mem_ctl.sv
// data_mem_ctl: parametrised data memory with init sweep, Ready handshake and 0/1-cycle reads.
// Define DATA_MEM_CTL_PARITY_EN to store an even-parity bit per word and expose ParityErr.
module data_mem_ctl
    import data_mem_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int AW = AW_DEF,
    parameter int RD_LAT = 0,
    parameter logic [W-1:0] INIT_VAL = '0
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Clear,
    input  logic          MemWrite,
    input  logic          MemRead,
    input  logic [AW-1:0] DataAddress,
    input  logic [W-1:0]  DataIn,
    output logic [W-1:0]  DataOut,
    output logic          Ready,
    output logic          ReadValid,
`ifdef DATA_MEM_CTL_PARITY_EN
    output logic          ParityErr,
`endif
    output logic [AW-1:0] SweepAddr
);
`ifdef DATA_MEM_CTL_PARITY_EN
    localparam int SW = W + 1;
`else
    localparam int SW = W;
`endif
    mem_state_t state;
    logic [AW-1:0] cnt;
    logic sweep, we, rd_ok;
    logic [AW-1:0] waddr;
    logic [W-1:0] wdata_d;
    logic [SW-1:0] wword, rword;
    assign SweepAddr = cnt;
    // cnt wraps back to 0 on the final sweep write, so it already reads 0 in IDLE.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= INIT;
            cnt   <= '0;
            Ready <= 1'b0;
        end else if (state == INIT) begin
            cnt   <= Clear ? '0 : cnt + AW'(1);
            state <= (!Clear && cnt == '1) ? IDLE : INIT;
            Ready <= !Clear && cnt == '1;
        end else if (Clear) begin
            state <= INIT;
            Ready <= 1'b0;
        end
    end
    assign sweep   = state == INIT;
    assign we      = sweep | MemWrite;
    assign waddr   = sweep ? cnt : DataAddress;
    assign wdata_d = sweep ? INIT_VAL : DataIn;
    assign rd_ok   = MemRead & Ready;
`ifdef DATA_MEM_CTL_PARITY_EN
    assign wword = {calc_parity(PAR_MAX_W'(wdata_d)), wdata_d};
`else
    assign wword = wdata_d;
`endif
    mem_array #(.DW(SW), .AW(AW)) u_mem (
        .Clk   (Clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wword),
        .raddr (DataAddress),
        .rdata (rword)
    );
    generate
        if (RD_LAT == 0) begin : g_comb
            assign DataOut   = rword[W-1:0];
            assign ReadValid = rd_ok;
`ifdef DATA_MEM_CTL_PARITY_EN
            assign ParityErr = ^rword;
`endif
        end else begin : g_reg
            // Shared pointer: a concurrent write always hits the read address, so bypass DataIn.
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    DataOut   <= '0;
                    ReadValid <= 1'b0;
`ifdef DATA_MEM_CTL_PARITY_EN
                    ParityErr <= 1'b0;
`endif
                end else begin
                    ReadValid <= rd_ok;
                    if (rd_ok) begin
                        DataOut   <= MemWrite ? DataIn : rword[W-1:0];
`ifdef DATA_MEM_CTL_PARITY_EN
                        ParityErr <= MemWrite ? 1'b0 : ^rword;
`endif
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_data_mem_ctl.sv
// tb_data_mem_ctl: scoreboard bench running a RD_LAT=0 and a RD_LAT=1 instance on shared stimulus
module tb_data_mem_ctl;
    logic Clk = 0, Reset_n = 1, Clear, MemWrite, MemRead;
    logic [7:0] DataAddress, DataIn;
    logic [7:0] dout0, dout1, sw0, sw1;
    logic rdy0, rdy1, rv0, rv1, pe0, pe1;
    always #5 Clk = ~Clk;

    data_mem_ctl #(.W(8), .AW(8), .RD_LAT(0), .INIT_VAL(8'hA5)) u0 (
        .Clk(Clk), .Reset_n(Reset_n), .Clear(Clear), .MemWrite(MemWrite), .MemRead(MemRead),
        .DataAddress(DataAddress), .DataIn(DataIn), .DataOut(dout0), .Ready(rdy0),
        .ReadValid(rv0),
`ifdef DATA_MEM_CTL_PARITY_EN
        .ParityErr(pe0),
`endif
        .SweepAddr(sw0));
    data_mem_ctl #(.W(8), .AW(8), .RD_LAT(1), .INIT_VAL(8'hA5)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .Clear(Clear), .MemWrite(MemWrite), .MemRead(MemRead),
        .DataAddress(DataAddress), .DataIn(DataIn), .DataOut(dout1), .Ready(rdy1),
        .ReadValid(rv1),
`ifdef DATA_MEM_CTL_PARITY_EN
        .ParityErr(pe1),
`endif
        .SweepAddr(sw1));
`ifndef DATA_MEM_CTL_PARITY_EN
    assign pe0 = 1'b0;
    assign pe1 = 1'b0;
`endif

    typedef struct { logic [7:0] d; logic p; int due; } item_t;
    item_t q[2][$];
    int vectors = 0, miscompares = 0, cyc = 0;
    logic run = 0;
    // Reference model: word contents, injected-fault flags, cycles left in the current sweep.
    logic [7:0] mem [256];
    logic flip [256];
    int left = 256;
    logic m_ready = 0;
    logic exp_ready = 0;
    logic [7:0] exp_sw = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic rv, input logic [7:0] d, input logic p);
        item_t it;
        logic due_now;
        due_now = q[k].size() != 0 && q[k][0].due <= cyc;
        chk($sformatf("readvalid%0d", k), rv, due_now);
        if (due_now) begin
            it = q[k].pop_front();
            if (rv) begin
                chk($sformatf("dataout%0d", k), d, it.d);
`ifdef DATA_MEM_CTL_PARITY_EN
                chk($sformatf("parityerr%0d", k), p, it.p);
`endif
            end
        end
    endtask

    always @(negedge Clk) begin
        if (run && Reset_n) begin
            chk("ready0", rdy0, exp_ready);
            chk("ready1", rdy1, exp_ready);
            chk("sweepaddr0", sw0, exp_sw);
            chk("sweepaddr1", sw1, exp_sw);
            mon(0, rv0, dout0, pe0);
            mon(1, rv1, dout1, pe1);
        end
    end

    // Apply one cycle of inputs (called at posedge+1) and advance the model across the next edge.
    task automatic cyc_drive(input logic clr, input logic w, input logic r,
                             input logic [7:0] a, input logic [7:0] din);
        Clear = clr; MemWrite = w; MemRead = r; DataAddress = a; DataIn = din;
        if (m_ready && r) begin
            q[0].push_back('{mem[a], flip[a], cyc});
            q[1].push_back('{w ? din : mem[a], w ? 1'b0 : flip[a], cyc + 1});
        end
        @(posedge Clk); #1;
        if (m_ready) begin
            if (w) begin mem[a] = din; flip[a] = 0; end
            if (clr) begin m_ready = 0; left = 256; end
        end else begin
            left = clr ? 256 : left - 1;
            if (left == 0) begin
                m_ready = 1;
                for (int i = 0; i < 256; i++) begin mem[i] = 8'hA5; flip[i] = 0; end
            end
        end
        exp_ready = m_ready;
        exp_sw = m_ready ? 8'd0 : 8'(256 - left);
    endtask

    task automatic idle(); cyc_drive(0, 0, 0, 8'd0, 8'd0); endtask
    task automatic rd(input logic [7:0] a); cyc_drive(0, 0, 1, a, 8'd0); endtask

    task automatic wait_ready();
        for (int i = 0; i < 600 && !m_ready; i++)
            cyc_drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        chk("ready_timeout", rdy0, 1'b1);
    endtask

    task automatic do_reset();
        Reset_n = 0; #1;
        chk("rst_ready0", rdy0, 1'b0);
        chk("rst_ready1", rdy1, 1'b0);
        chk("rst_sweep0", sw0, 8'd0);
        chk("rst_sweep1", sw1, 8'd0);
        chk("rst_rvalid1", rv1, 1'b0);
        chk("rst_dataout1", dout1, 8'd0);
`ifdef DATA_MEM_CTL_PARITY_EN
        chk("rst_parity1", pe1, 1'b0);
`endif
        q[0].delete(); q[1].delete();
        @(posedge Clk); #1;
        Reset_n = 1; left = 256; m_ready = 0; exp_ready = 0; exp_sw = 0;
    endtask

    initial begin
        Clear = 0; MemWrite = 0; MemRead = 0; DataAddress = 0; DataIn = 0;
        for (int i = 0; i < 256; i++) begin mem[i] = 0; flip[i] = 0; end
        @(posedge Clk); #1;
        do_reset();
        run = 1;
        wait_ready();
        rd(8'd0); rd(8'd17); rd(8'd255);
        cyc_drive(0, 1, 0, 8'h10, 8'h3C); rd(8'h10);
        cyc_drive(0, 1, 1, 8'h40, 8'h77); rd(8'h40);
        cyc_drive(1, 0, 0, 8'd0, 8'd0);
        cyc_drive(0, 1, 0, 8'h05, 8'hFF);
        wait_ready();
        rd(8'h05);
        cyc_drive(1, 0, 0, 8'd0, 8'd0);
        repeat (99) idle();
        cyc_drive(1, 0, 0, 8'd0, 8'd0);
        wait_ready();
        for (int i = 0; i < 2000; i++)
            cyc_drive(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 15)), 8'($urandom));
        wait_ready();
        cyc_drive(1, 0, 0, 8'd0, 8'd0);
        repeat (50) idle();
        do_reset();
        wait_ready();
        rd(8'd0); rd(8'h80);
`ifdef DATA_MEM_CTL_PARITY_EN
        u0.u_mem.core[8'h20][8] = ~u0.u_mem.core[8'h20][8];
        u1.u_mem.core[8'h20][8] = ~u1.u_mem.core[8'h20][8];
        flip[8'h20] = 1;
        rd(8'h20); rd(8'h21); rd(8'h20);
        cyc_drive(0, 1, 1, 8'h20, 8'h12);
        rd(8'h20);
`endif
        repeat (3) idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
